sobol_to_int32: RTL and testbench

SOBOL_TO_INT32 -- requirements
Module: sobol_to_int32

---
 rtl/sobol_pkg.sv | 41 ++++
 rtl/sobol_lzb.sv | 22 ++
 rtl/sobol_to_int32.sv | 68 ++++++
 tb/tb_sobol_to_int32.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sobol_pkg.sv
// Shared constants for the Sobol-to-INT32 generator: widths, the INT32
// offset and both 32-entry direction-number tables. Entry [k-1] of a table
// holds v_k. The optional build macro SOBOL_DIM2_EN is consumed by
// sobol_to_int32, which selects between the two tables.
package sobol_pkg;

  localparam int SOBOL_W = 32;

  // XOR with this maps an unsigned fraction onto the full signed INT32 range.
  localparam logic [SOBOL_W-1:0] INT32_OFFSET = 32'h8000_0000;

  typedef logic [SOBOL_W-1:0][SOBOL_W-1:0] dir_tab_t;

  // Dimension 1 (van der Corput): m_k = 1, so v_k = 1 << (32-k).
  function automatic dir_tab_t build_dim1();
    dir_tab_t t;
    t = '0;
    for (int k = 1; k <= SOBOL_W; k++) begin
      t[k-1] = 32'd1 << (SOBOL_W - k);
    end
    return t;
  endfunction

  // Dimension 2 (polynomial x+1): m_1 = 1, m_k = (2*m_(k-1)) ^ m_(k-1).
  // m_k < 2^k, so a 64-bit accumulator never loses bits before the shift.
  function automatic dir_tab_t build_dim2();
    dir_tab_t    t;
    logic [63:0] m;
    t = '0;
    m = 64'd1;
    for (int k = 1; k <= SOBOL_W; k++) begin
      t[k-1] = 32'(m << (SOBOL_W - k));
      m      = (m << 1) ^ m;
    end
    return t;
  endfunction

  localparam dir_tab_t DIM1_V = build_dim1();
  localparam dir_tab_t DIM2_V = build_dim2();

endpackage

// File: rtl/sobol_lzb.sv
// Least-significant-zero-bit priority encoder. idx is the position of the
// lowest 0 bit of n; all_ones flags that n has no 0 bit (idx is then 0).
module sobol_lzb
  import sobol_pkg::*;
(
  input  logic [SOBOL_W-1:0] n,
  output logic [4:0]         idx,
  output logic               all_ones
);

  // Scan high to low so the lowest zero bit is the last, winning, write.
  always_comb begin
    idx = 5'd0;
    for (int i = SOBOL_W - 1; i >= 0; i--) begin
      if (!n[i]) begin
        idx = i[4:0];
      end
    end
    all_ones = &n;
  end

endmodule

// File: rtl/sobol_to_int32.sv
// Sobol sequence generator producing one signed INT32 point per enabled
// cycle. Build option: define SOBOL_DIM2_EN for dimension-2 direction
// numbers; leave it undefined for dimension 1 (van der Corput).
//
// start is a plain level enable rather than a valid/ready handshake: every
// rising edge that sees start=1 (and rst_n=1) advances one point, and res
// carries that point from the following cycle on. There is no backpressure.
module sobol_to_int32
  import sobol_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [SOBOL_W-1:0] res
);

`ifdef SOBOL_DIM2_EN
  localparam dir_tab_t V_TAB = DIM2_V;
`else
  localparam dir_tab_t V_TAB = DIM1_V;
`endif

  logic [SOBOL_W-1:0] n_q,   n_d;
  logic [SOBOL_W-1:0] x_q,   x_d;
  logic [SOBOL_W-1:0] res_q, res_d;
  logic [4:0]         lzb_idx;
  logic               lzb_all_ones;

  sobol_lzb u_lzb (
    .n        (n_q),
    .idx      (lzb_idx),
    .all_ones (lzb_all_ones)
  );

  // Next-state: Gray-code style update x ^= v_(c+1); a full index restarts.
  always_comb begin
    n_d   = n_q;
    x_d   = x_q;
    res_d = res_q;
    if (start) begin
      if (lzb_all_ones) begin
        n_d   = '0;
        x_d   = '0;
        res_d = INT32_OFFSET;
      end else begin
        n_d   = n_q + 32'd1;
        x_d   = x_q ^ V_TAB[lzb_idx];
        res_d = x_d ^ INT32_OFFSET;
      end
    end
  end

  // State registers; reset clears progress immediately, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q   <= '0;
      x_q   <= '0;
      res_q <= INT32_OFFSET;
    end else begin
      n_q   <= n_d;
      x_q   <= x_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: tb/tb_sobol_to_int32.sv
// Directed bench for sobol_to_int32. The reference model tracks only the
// point count p since reset and derives x from the Gray code of p, which is
// independent of how the DUT walks the sequence.
module tb_sobol_to_int32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] res;

  sobol_to_int32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .res   (res)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] tb_v [32];
  logic [31:0] model_p;
  logic        wrap_pending;
  logic        chk_en;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] model_res(input logic [31:0] p);
    logic [31:0] g;
    logic [31:0] x;
    g = p ^ (p >> 1);
    x = '0;
    for (int k = 0; k < 32; k++) begin
      if (g[k]) x = x ^ tb_v[k];
    end
    return x ^ 32'h8000_0000;
  endfunction

  // Point counter: reset clears it, each enabled edge counts one point.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_p <= '0;
    else if (start) model_p <= wrap_pending ? 32'd0 : model_p + 32'd1;
  end

  // Per-cycle compare of res against the model.
  always @(negedge clk) begin
    if (chk_en) check("cmp_res", res, model_res(model_p));
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after a rising edge; literal checks are
  // sampled 1 unit after a rising edge.
  task automatic drive_after_edge(input logic s);
    @(posedge clk);
    #2;
    start = s;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_active", res, 32'h8000_0000);
    #1;
    rst_n = 1'b1;
  endtask

  // Run n enabled edges, checking each new point against exp_q.
  task automatic run_points(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) check(name, res, exp_q.pop_front());
    end
  endtask

  logic [31:0] held;

  initial begin
    logic [63:0] m;
    rst_n        = 1'b0;
    start        = 1'b0;
    wrap_pending = 1'b0;
    chk_en       = 1'b0;

    m = 64'd1;
    for (int k = 0; k < 32; k++) begin
`ifdef SOBOL_DIM2_EN
      tb_v[k] = 32'(m << (31 - k));
      m       = (m << 1) ^ m;
`else
      tb_v[k] = 32'h8000_0000 >> k;
`endif
    end

    // Literal pins on the model itself.
    check("model_p0", model_res(32'd0), 32'h8000_0000);
`ifdef SOBOL_DIM2_EN
    check("model_p3", model_res(32'd3), 32'h4000_0000);
`else
    check("model_p3", model_res(32'd3), 32'hC000_0000);
`endif

    // Reset, then five idle cycles holding the reset value.
    do_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_hold", res, 32'h8000_0000);
    end

    // First five points from reset.
`ifdef SOBOL_DIM2_EN
    exp_q = '{32'h0000_0000, 32'hC000_0000, 32'h4000_0000, 32'hE000_0000, 32'h6000_0000};
`else
    exp_q = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'hE000_0000, 32'h6000_0000};
`endif
    #1;
    start = 1'b1;
    run_points(5, "seq5");

    // Hold: three points, four stalled cycles, then the fourth point.
    do_reset();
`ifdef SOBOL_DIM2_EN
    exp_q = '{32'h0000_0000, 32'hC000_0000, 32'h4000_0000, 32'hE000_0000};
`else
    exp_q = '{32'h0000_0000, 32'h4000_0000, 32'hC000_0000, 32'hE000_0000};
`endif
    #1;
    start = 1'b1;
    run_points(3, "hold_pre");
    held = res;
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("hold_frozen", res, held);
    end
    #1;
    start = 1'b1;
    run_points(1, "hold_resume");

    // Run to ten points, bounded by a cycle budget.
    begin
      int budget;
      budget = 50;
      while (model_p != 32'd10 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      check("reach_p10", model_p, 32'd10);
    end

    // Async reset pulse between edges; start stays high.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", res, 32'h8000_0000);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_async", res, 32'h0000_0000);

    // Wrap: deposit the all-ones index and advance once.
    #1;
    start        = 1'b0;
    chk_en       = 1'b0;
    dut.n_q      = 32'hFFFF_FFFF;
    wrap_pending = 1'b1;
    start        = 1'b1;
    @(posedge clk);
    #1;
    wrap_pending = 1'b0;
    check("wrap_n", dut.n_q, 32'd0);
    check("wrap_x", dut.x_q, 32'd0);
    check("wrap_res", res, 32'h8000_0000);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("post_wrap", res, 32'h0000_0000);
    drive_after_edge(1'b0);
    repeat (3) @(posedge clk);

    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
